// File: rtl/sub_seq_slice.sv
// Slice-serial subtractor: d = a - b - bi, computed SLICE bits per clock,
// least significant slice first, with the borrow carried in a register
// between slices. Start/busy/done handshake; results are held until the
// next completion or reset.
module sub_seq_slice #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov,
    output logic             z
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold last result
    // RUN   | one slice per edge, cnt = slice index being processed
    // DONE  | done pulse cycle; start here is accepted back-to-back
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // Operands shift right one slice per edge so the active slice is always
    // the low SLICE bits; after the last shift the top slice's sign bits are
    // what remain at position SLICE-1.
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 borrow_q;
    // Partial difference accumulates from the top down; it only becomes
    // visible on d once the final slice is merged in.
    logic [WIDTH-SLICE-1:0] acc_q;

    logic [SLICE:0]       sum;
    logic [WIDTH-1:0]     d_next;
    logic                 last_slice;

    // One slice of a - b - borrow, done as a + ~b + ~borrow.
    always_comb begin
        sum        = {1'b0, a_q[SLICE-1:0]} + {1'b0, ~b_q[SLICE-1:0]}
                   + {{SLICE{1'b0}}, ~borrow_q};
        d_next     = {sum[SLICE-1:0], acc_q};
        last_slice = (cnt == CNT_W'(N - 1));
    end

    // Sequencer, slice datapath and registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            acc_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            bo       <= 1'b0;
            ov       <= 1'b0;
            z        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bi;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> SLICE;
                    b_q      <= b_q >> SLICE;
                    borrow_q <= ~sum[SLICE];
                    acc_q    <= d_next[WIDTH-1:SLICE];
                    cnt      <= cnt + CNT_W'(1);
                    if (last_slice) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= d_next;
                        bo    <= ~sum[SLICE];
                        ov    <= (a_q[SLICE-1] != b_q[SLICE-1])
                              && (sum[SLICE-1] != a_q[SLICE-1]);
                        z     <= (d_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_seq_slice.sv
// Directed bench for sub_seq_slice with default parameters (32/4, 8 slices).
module tb_sub_seq_slice;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;

    int total = 0;
    int bad   = 0;

    sub_seq_slice #(.WIDTH(32), .SLICE(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bi      (bi),
        .busy    (busy),
        .done    (done),
        .d       (d),
        .bo      (bo),
        .ov      (ov),
        .z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] exp_d;
        logic        exp_bo;
        logic        exp_ov;
        logic        exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait for done after the start edge; returns edges counted and whether
    // busy stayed high until done appeared.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic op_bi, input logic [31:0] exp_d, input logic exp_bo,
                         input logic exp_ov, input logic exp_z);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        a = op_a; b = op_b; bi = op_bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, busy_ok);
        chk({name, " latency"}, 32'(lat), 32'd8);
        chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
        chk({name, " d"}, d, exp_d);
        chk({name, " bo"}, {31'd0, bo}, {31'd0, exp_bo});
        chk({name, " ov"}, {31'd0, ov}, {31'd0, exp_ov});
        chk({name, " z"}, {31'd0, z}, {31'd0, exp_z});
        @(posedge clk); #1;
        chk({name, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic seen_done;

        vecs[0] = '{32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0001_0000,  32'd1,          1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'd3,          32'd5,          1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h1234_5678,  32'h1234_5678,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h1234_5678,  32'h1234_5678,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst d", d, 32'd0);
        chk("rst flags", {29'd0, bo, ov, z}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle busy/done", {30'd0, busy, done}, 32'd0);
        chk("idle d", d, 32'd0);
        chk("idle flags", {29'd0, bo, ov, z}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
                  vecs[i].exp_d, vecs[i].exp_bo, vecs[i].exp_ov, vecs[i].exp_z);
        end

        // Second start during RUN is ignored.
        @(negedge clk);
        a = 32'd9; b = 32'd1; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        @(posedge clk); @(posedge clk);   // E1, E2
        @(negedge clk);
        a = 32'd0; b = 32'd0; start = 1'b1;
        @(posedge clk); #1;               // E3
        start = 1'b0;
        wait_done(lat, busy_ok);
        chk("ignore latency", 32'(lat + 3), 32'd8);
        chk("ignore d", d, 32'd8);

        // start held in the done cycle: accepted back-to-back.
        a = 32'd20; b = 32'd4; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;               // EN+1
        start = 1'b0;
        chk("b2b busy", {31'd0, busy}, 32'd1);
        chk("b2b done low", {31'd0, done}, 32'd0);
        chk("b2b d held", d, 32'd8);
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h1234_0000; bi = 1'b1;
        wait_done(lat, busy_ok);
        chk("b2b latency", 32'(lat), 32'd8);
        chk("b2b d", d, 32'd16);
        chk("b2b bo", {31'd0, bo}, 32'd0);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        @(negedge clk);
        a = 32'd100; b = 32'd1; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst d", d, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1 || d !== 32'd0) seen_done = 1'b1;
        end
        chk("midrst quiet", {31'd0, seen_done}, 32'd0);
        do_op("after rst", 32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_seq_slice.md
Name: sub_seq_slice

Overview:
- Multi-cycle unsigned/two's-complement subtractor: computes D = A − B − BI one SLICE-bit slice per clock, LSB slice first.
- Internal borrow is registered between slices.
- Start/busy/done handshake; sits beside the clocked CLA adders as the subtract path of the datapath.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SLICE
SLICE, 4, bits processed per cycle; N = WIDTH/SLICE cycles per operation

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk while not busy
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bi  input  1  borrow-in; captured on accepted start
busy  output  1  high while slices are being computed
done  output  1  one-cycle pulse; results valid
d  output  WIDTH  difference, a − b − bi mod 2^WIDTH
bo  output  1  borrow-out; 1 iff unsigned a < b + bi
ov  output  1  signed overflow; (a[W-1]!=b[W-1]) && (d[W-1]!=a[W-1])
z  output  1  d == 0

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (reset_n=0, any time, no clock needed): state=IDLE; busy, done, d, bo, ov, z all 0; slice counter 0; operand registers cleared.
- Reset mid-operation aborts the operation. No done pulse follows. Outputs read 0 after release.
- States:
  - IDLE: start=1 at edge E0 → latch a, b, bi; borrow reg=bi; cnt=0; go RUN (busy=1 after E0).
  - RUN: each edge computes slice cnt:
    - sum = a_k + ~b_k + ~borrow (SLICE+1 bits)
    - partial d_k = sum[SLICE-1:0]
    - borrow = ~sum[SLICE]
    - cnt++
  - RUN exit: at edge EN (the edge processing cnt=N-1), go DONE.
  - DONE: entered at EN.
    - busy=0; done=1 for exactly one cycle.
    - d, bo=final borrow, ov, z written to output regs at EN.
  - DONE exit: at edge EN+1 go IDLE, or go RUN if start=1 there (back-to-back accepted).
- Latency: done high in the cycle after edge EN, i.e. N cycles after the start edge; 8 for defaults. Throughput: one op per N+1 cycles.
- d/bo/ov/z change only at EN. They hold their values through IDLE until the next completion or reset. Partial results are internal and never visible on d.
- start while busy=1 is ignored. Operand inputs are don't-care outside the accepting edge.
- Inputs changing during RUN do not affect the result.
- Wrap-around: results are modulo 2^WIDTH. bo flags unsigned underflow; ov flags signed overflow. The two are independent.
- bi=1 with a=b gives all-ones, bo=1, z=0.

Test Plan:
1. Reset: assert reset_n=0 mid-clock with no edges -> busy=done=d=bo=ov=z=0 immediately. Release, idle 3 cycles -> all remain 0.
2. a=5, b=3, bi=0, start at E0 -> busy high E0..E8; done pulse in cycle after E8 only; d=0x00000002, bo=0, ov=0, z=0. Then a=0x00010000, b=1 -> d=0x0000FFFF, bo=0 (borrow ripples across 4 slices).
3. a=3, b=5 -> d=0xFFFFFFFE, bo=1, ov=0. a=0x80000000, b=1 -> d=0x7FFFFFFF, bo=0, ov=1. a=0x7FFFFFFF, b=0xFFFFFFFF -> d=0x80000000, bo=1, ov=1.
4. a=b=0x12345678, bi=0 -> d=0, z=1, bo=0. Same operands with bi=1 -> d=0xFFFFFFFF, z=0, bo=1.
5. Handshake:
   - start with a=9, b=1; pulse start again at E3 with a=0, b=0 -> ignored; result d=8.
   - start=1 held in the done cycle with a=20, b=4 -> second op accepted at EN+1; d=16 after 8 more edges.
   - Change a/b during RUN -> no effect on result.
6. Reset mid-op: start a=100, b=1; drive reset_n=0 at cycle 4 -> busy=0 at once. No done pulse for 12 cycles after release; d=0. A fresh op a=100, b=1 then yields d=99.
